// File: rtl/register_file.sv
// Architectural register file: two combinational read ports, x0 hardwired to zero, and a
// valid/ready writeback port that feeds the array through an in-order write buffer.
// Optional read bypass from the buffer and the incoming write: define REGFILE_BYPASS_EN.
module register_file #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned ADDR_WIDTH     = $clog2(NUM_REGS),
  parameter int unsigned BUF_DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         rs1_addr,
  input  logic [ADDR_WIDTH-1:0]         rs2_addr,
  output logic [REGISTER_WIDTH-1:0]     rs1_value,
  output logic [REGISTER_WIDTH-1:0]     rs2_value,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [REGISTER_WIDTH-1:0]     wr_data,
  input  logic                          port_busy,
  output logic [$clog2(BUF_DEPTH):0]    pending_count
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [REGISTER_WIDTH-1:0] regs_q     [NUM_REGS];
  logic [ADDR_WIDTH-1:0]     buf_addr_q [BUF_DEPTH];
  logic [REGISTER_WIDTH-1:0] buf_data_q [BUF_DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push;
  logic            drain;

  // Writes to x0 complete the handshake but are never enqueued.
  always_comb begin
    wr_ready = count_q < CntW'(BUF_DEPTH);
    push     = wr_valid && wr_ready && (wr_addr != '0);
    drain    = (count_q != '0) && !port_busy;
    head_d   = drain ? head_q + PtrW'(1) : head_q;
    tail_d   = push ? tail_q + PtrW'(1) : tail_q;
    count_d  = count_q + CntW'(push) - CntW'(drain);
  end

  assign pending_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        buf_addr_q[tail_q] <= wr_addr;
        buf_data_q[tail_q] <= wr_data;
      end
      if (drain) begin
        regs_q[buf_addr_q[head_q]] <= buf_data_q[head_q];
      end
    end
  end

  function automatic logic [REGISTER_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [REGISTER_WIDTH-1:0] value;
`ifdef REGFILE_BYPASS_EN
    logic [PtrW-1:0] idx;
`endif
    value = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    for (int i = 0; i < BUF_DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (buf_addr_q[idx] == addr)) begin
        value = buf_data_q[idx];
      end
    end
    // Held in reset, the incoming write must not leak onto the read ports.
    if (push && rst_n && (wr_addr == addr)) begin
      value = wr_data;
    end
`endif
    if (addr == '0) begin
      value = '0;
    end
    return value;
  endfunction

  always_comb begin
    rs1_value = read_port(rs1_addr);
    rs2_value = read_port(rs2_addr);
  end

endmodule

// File: tb/tb_register_file.sv
// Randomised scoreboard bench for register_file; the reference model is a plain array plus
// a FIFO queue of pending writes.
module tb_register_file;

  localparam int Depth = 2;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_value, rs2_value;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        port_busy;
  logic [1:0]  pending_count;

  register_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_value     (rs1_value),
    .rs2_value     (rs2_value),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .port_busy     (port_busy),
    .pending_count (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A stalled request must be held unchanged until accepted.
  assert property (@(posedge clk) disable iff (!rst_n)
    (wr_valid && !wr_ready) |=> (wr_valid && $stable(wr_addr) && $stable(wr_data)));

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [1:0]  pend;
    logic        rdy;
  } exp_t;

  logic [31:0] arr [32];
  ent_t        pq [$];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic acc,
                                             input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = arr[a];
`ifdef REGFILE_BYPASS_EN
    foreach (pq[i]) if (pq[i].a == a) v = pq[i].d;
    if (acc && wa == a) v = wd;
`else
    if (acc && wa == a && wd == 32'hx) v = wd;
`endif
    return v;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: compares whatever the DUT presents against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs1_value", rs1_value, e.rs1);
        chk("rs2_value", rs2_value, e.rs2);
        chk("pending_count", 32'(pending_count), 32'(e.pend));
        chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
      end
    end
  end

  task automatic cycle(input logic rst_lvl, input logic pulse, input logic v,
                       input logic [4:0] wa, input logic [31:0] wd, input logic busy,
                       input logic [4:0] r1, input logic [4:0] r2, output logic acc);
    exp_t e;
    ent_t ent;
    logic rdy;
    @(negedge clk);
    rst_n     = rst_lvl && !pulse;
    wr_valid  = v;
    wr_addr   = wa;
    wr_data   = wd;
    port_busy = busy;
    rs1_addr  = r1;
    rs2_addr  = r2;
    if (!rst_n) begin
      pq.delete();
      foreach (arr[i]) arr[i] = 32'd0;
    end
    rdy   = pq.size() < Depth;
    acc   = v && rdy && rst_n;
    e.rs1 = model_read(r1, acc, wa, wd);
    e.rs2 = model_read(r2, acc, wa, wd);
    e.pend = 2'(pq.size());
    e.rdy  = rdy;
    exp_q.push_back(e);
    if (pulse) begin
      #3;
      rst_n = 1'b1;
    end
    @(posedge clk);
    if (rst_n) begin
      if (pq.size() > 0 && !busy) begin
        ent = pq.pop_front();
        arr[ent.a] = ent.d;
      end
      if (acc && wa != 5'd0) begin
        ent.a = wa;
        ent.d = wd;
        pq.push_back(ent);
      end
    end
  endtask

  task automatic send(input logic [4:0] wa, input logic [31:0] wd, input logic busy,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b1, wa, wd, busy, r1, r2, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: request x%0d not accepted after %0d cycles, required accept",
               wa, n);
    end
  endtask

  task automatic idle(input logic busy, input logic [4:0] r1, input logic [4:0] r2);
    logic acc;
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, busy, r1, r2, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic        cv;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic [4:0]  r1, r2;

    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    port_busy = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    foreach (arr[i]) arr[i] = 32'd0;

    // Reset held with a live write request.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 5'(i + 3), 32'hCAFE0000 + i, 1'b0, 5'(i * 4), 5'(i * 4 + 1), acc);
    end
    idle(1'b0, 5'd5, 5'd0);

    // Basic write and latency.
    send(5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
    idle(1'b0, 5'd5, 5'd5);
    idle(1'b0, 5'd5, 5'd0);

    // x0 write is accepted but discarded.
    send(5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
    idle(1'b0, 5'd0, 5'd5);

    // Backpressure with the array port stolen.
    send(5'd1, 32'd1, 1'b1, 5'd1, 5'd2);
    send(5'd2, 32'd2, 1'b1, 5'd1, 5'd2);
    cycle(1'b1, 1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd1, 5'd3, acc);
    cycle(1'b1, 1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd2, 5'd3, acc);
    send(5'd3, 32'd3, 1'b0, 5'd1, 5'd2);
    idle(1'b0, 5'd1, 5'd2);
    idle(1'b0, 5'd3, 5'd2);
    idle(1'b0, 5'd3, 5'd1);

    // Same-address ordering.
    send(5'd7, 32'hA, 1'b1, 5'd7, 5'd7);
    send(5'd7, 32'hB, 1'b1, 5'd0, 5'd7);
    idle(1'b1, 5'd7, 5'd7);
    idle(1'b0, 5'd7, 5'd7);
    idle(1'b0, 5'd7, 5'd7);
    idle(1'b0, 5'd7, 5'd7);

    // Reset pulse while entries are pending.
    send(5'd4, 32'h44, 1'b1, 5'd4, 5'd6);
    send(5'd6, 32'h66, 1'b1, 5'd4, 5'd6);
    cycle(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd6, acc);
    idle(1'b0, 5'd4, 5'd6);
    idle(1'b0, 5'd4, 5'd6);
    idle(1'b0, 5'd5, 5'd7);

    // Random traffic, favouring a few registers to provoke hazards.
    cv  = 1'b0;
    ca  = '0;
    cd  = '0;
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!cv || acc) begin
        cv = $urandom_range(0, 3) != 0;
        ca = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        cd = $urandom;
      end
      r1 = ($urandom_range(0, 1) == 1) ? ca : 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 31));
      cycle(1'b1, 1'b0, cv, ca, cd, $urandom_range(0, 2) == 0, r1, r2, acc);
    end
    if (cv && !acc) send(ca, cd, 1'b0, ca, 5'd0);
    for (int i = 0; i < 8; i++) idle(1'b0, 5'(i), 5'(i + 8));

    repeat (2) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
